// File: rtl/elevator_pkg.sv
// Shared status encoding and floor geometry for the elevator dispatcher slice.
package elevator_pkg;

  localparam int NUM_FLOORS = 8;
  localparam int FLOOR_W    = 3;

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    MOVE_UP    = 4'd1,
    MOVE_DOWN  = 4'd2,
    DOOR_OPEN  = 4'd7,
    DOOR_CLOSE = 4'd8
  } status_t;

endpackage

// File: rtl/elevator_req_scan.sv
// Combinational request scan: demand above/below the car and collective stop rules.
module elevator_req_scan
  import elevator_pkg::*;
(
  input  logic [NUM_FLOORS-1:0] pend,
  input  logic [NUM_FLOORS-1:0] upcall,
  input  logic [NUM_FLOORS-1:0] downcall,
  input  logic [NUM_FLOORS-1:0] floor_btn,
  input  logic [FLOOR_W-1:0]    floor,
  input  logic                  dir_up,
  output logic                  above,
  output logic                  below,
  output logic                  stop_up,
  output logic                  stop_down,
  output logic                  go_up
);

  logic [NUM_FLOORS-1:0] above_mask;
  logic [NUM_FLOORS-1:0] below_mask;

  // Shifting out past the top bit makes both masks empty at the boundary floors.
  assign above_mask = {{(NUM_FLOORS-1){1'b1}}, 1'b0} << floor;
  assign below_mask = ~({NUM_FLOORS{1'b1}} << floor);

  assign above     = |(pend & above_mask);
  assign below     = |(pend & below_mask);
  assign stop_up   = floor_btn[floor] | upcall[floor]   | (downcall[floor] & ~above);
  assign stop_down = floor_btn[floor] | downcall[floor] | (upcall[floor]   & ~below);
  assign go_up     = above & (dir_up | ~below);

endmodule

// File: rtl/elevator_dispatcher.sv
// Collective (SCAN) elevator scheduler: travel/door counters and the dispatch FSM.
module elevator_dispatcher
  import elevator_pkg::*;
#(
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] upcall,
  input  logic [NUM_FLOORS-1:0] downcall,
  input  logic [NUM_FLOORS-1:0] floor_btn,
  output logic [FLOOR_W-1:0]    floor,
  output logic [3:0]            status,
  output logic                  dir_up,
  output logic                  door_open
);

  localparam int TCW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
  localparam int DCW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [TCW-1:0] TLAST = TCW'(TRAVEL_CYCLES - 1);
  localparam logic [DCW-1:0] DLAST = DCW'(DOOR_CYCLES - 1);
  localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(NUM_FLOORS - 1);

  status_t              state;
  logic [FLOOR_W-1:0]   floor_q;
  logic                 dir_q;
  logic                 door_q;
  logic [TCW-1:0]       tcnt;
  logic [DCW-1:0]       dcnt;
  logic                 arrive;
  logic [NUM_FLOORS-1:0] pend;
  logic                 above, below, stop_up, stop_down, go_up;

  assign pend = upcall | downcall | floor_btn;

  elevator_req_scan u_scan (
    .pend      (pend),
    .upcall    (upcall),
    .downcall  (downcall),
    .floor_btn (floor_btn),
    .floor     (floor_q),
    .dir_up    (dir_q),
    .above     (above),
    .below     (below),
    .stop_up   (stop_up),
    .stop_down (stop_down),
    .go_up     (go_up)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      floor_q <= '0;
      dir_q   <= 1'b1;
      door_q  <= 1'b0;
      tcnt    <= '0;
      dcnt    <= '0;
      arrive  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pend[floor_q]) begin
            state  <= DOOR_OPEN;
            door_q <= 1'b1;
            dcnt   <= '0;
          end else if (go_up) begin
            state <= MOVE_UP;
            dir_q <= 1'b1;
          end else if (below) begin
            state <= MOVE_DOWN;
            dir_q <= 1'b0;
          end
        end
        MOVE_UP: begin
          // After each floor step, one cycle judges the new floor before moving on.
          if (arrive) begin
            arrive <= 1'b0;
            if (stop_up) begin
              state  <= DOOR_OPEN;
              door_q <= 1'b1;
              dcnt   <= '0;
            end else if (!above) begin
              state <= IDLE;
            end
          end else if (tcnt == TLAST) begin
            tcnt   <= '0;
            arrive <= 1'b1;
            if (floor_q != TOP_FLOOR) floor_q <= floor_q + FLOOR_W'(1);
          end else begin
            tcnt <= tcnt + TCW'(1);
          end
        end
        MOVE_DOWN: begin
          if (arrive) begin
            arrive <= 1'b0;
            if (stop_down) begin
              state  <= DOOR_OPEN;
              door_q <= 1'b1;
              dcnt   <= '0;
            end else if (!below) begin
              state <= IDLE;
            end
          end else if (tcnt == TLAST) begin
            tcnt   <= '0;
            arrive <= 1'b1;
            if (floor_q != '0) floor_q <= floor_q - FLOOR_W'(1);
          end else begin
            tcnt <= tcnt + TCW'(1);
          end
        end
        DOOR_OPEN: begin
          if (dcnt == DLAST) begin
            state  <= DOOR_CLOSE;
            door_q <= 1'b0;
            dcnt   <= '0;
          end else begin
            dcnt <= dcnt + DCW'(1);
          end
        end
        DOOR_CLOSE: state <= IDLE;
        default:    state <= IDLE;
      endcase
    end
  end

  assign floor     = floor_q;
  assign status    = state;
  assign dir_up    = dir_q;
  assign door_open = door_q;

endmodule

// File: tb/tb_elevator_dispatcher.sv
// Scenario and randomized bench for elevator_dispatcher against a behavioural car model.
module tb_elevator_dispatcher;

  localparam int T = 4;
  localparam int D = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] up_r = '0, dn_r = '0, fb_r = '0;
  logic [2:0] floor;
  logic [3:0] status;
  logic       dir_up, door_open;

  int total = 0;
  int bad   = 0;

  // behavioural car model
  int         m_floor = 0;
  logic [3:0] m_status = 4'd0;
  logic       m_dir = 1'b1;
  int         m_tc = 0, m_dc = 0;
  bit         m_arr = 0;

  int         door_q[$];
  logic [3:0] prev_st = 4'd0;

  elevator_dispatcher #(.TRAVEL_CYCLES(T), .DOOR_CYCLES(D)) dut (
    .clk(clk), .rst(rst), .upcall(up_r), .downcall(dn_r), .floor_btn(fb_r),
    .floor(floor), .status(status), .dir_up(dir_up), .door_open(door_open)
  );

  always #5 clk = ~clk;

  task automatic model_step();
    logic [7:0] p;
    bit ab, be, stop, go;
    p  = up_r | dn_r | fb_r;
    ab = 0;
    be = 0;
    for (int i = 0; i < 8; i++) begin
      if (p[i] && i > m_floor) ab = 1;
      if (p[i] && i < m_floor) be = 1;
    end
    if (rst) begin
      m_floor = 0; m_status = 4'd0; m_dir = 1'b1; m_tc = 0; m_dc = 0; m_arr = 0;
      return;
    end
    case (m_status)
      4'd0: begin
        if (p[m_floor]) begin m_status = 4'd7; m_dc = 0; end
        else if (ab && (m_dir || !be)) begin m_status = 4'd1; m_dir = 1'b1; end
        else if (be) begin m_status = 4'd2; m_dir = 1'b0; end
      end
      4'd1, 4'd2: begin
        if (m_arr) begin
          m_arr = 0;
          if (m_status == 4'd1) begin
            stop = fb_r[m_floor] || up_r[m_floor] || (dn_r[m_floor] && !ab);
            go   = ab;
          end else begin
            stop = fb_r[m_floor] || dn_r[m_floor] || (up_r[m_floor] && !be);
            go   = be;
          end
          if (stop) begin m_status = 4'd7; m_dc = 0; end
          else if (!go) m_status = 4'd0;
        end else if (m_tc == T - 1) begin
          m_tc = 0;
          m_arr = 1;
          m_floor = m_floor + ((m_status == 4'd1) ? 1 : -1);
        end else begin
          m_tc++;
        end
      end
      4'd7: begin
        if (m_dc == D - 1) begin m_status = 4'd8; m_dc = 0; end
        else m_dc++;
      end
      default: m_status = 4'd0;
    endcase
  endtask

  // One clock: model follows the sampled inputs, the request buffer clears a served floor.
  task automatic tick();
    logic [3:0] ps;
    int pf;
    @(posedge clk);
    ps = m_status;
    pf = m_floor;
    model_step();
    #1;
    if (ps == 4'd7) begin
      up_r[pf] = 1'b0; dn_r[pf] = 1'b0; fb_r[pf] = 1'b0;
    end
    if (status == 4'd7 && prev_st != 4'd7) door_q.push_back(int'(floor));
    prev_st = status;
  endtask

  function automatic logic [8:0] exp_vec();
    return {3'(m_floor), m_status, m_dir, (m_status == 4'd7)};
  endfunction

  function automatic logic [8:0] obs();
    return {floor, status, dir_up, door_open};
  endfunction

  function automatic bit quiet();
    return (m_status == 4'd0) && ((up_r | dn_r | fb_r) == 8'h00);
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    door_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int c = 0; c < 60; c++) begin
      if (c == 10) rst = 1'b0;
      tick();
      total++;
      if (obs() !== exp_vec()) begin
        bad++;
        $display("FAIL reset c=%0d got=%h want=%h", c, obs(), exp_vec());
      end
    end
    total++;
    if (obs() !== {3'd0, 4'd0, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL reset_idle got=%h want=%h", obs(), {3'd0, 4'd0, 1'b1, 1'b0});
    end
  endtask

  task automatic test_single_call();
    int first7 = -1, n7 = 0, n8 = 0;
    door_q.delete();
    fb_r[3] = 1'b1;
    for (int c = 0; c < 300; c++) begin
      tick();
      total++;
      if (obs() !== exp_vec()) begin
        bad++;
        $display("FAIL single c=%0d got=%h want=%h", c, obs(), exp_vec());
      end
      if (status == 4'd7 && first7 < 0) first7 = c + 1;
      if (status == 4'd7) n7++;
      if (status == 4'd8) n8++;
      if (quiet()) break;
    end
    total++;
    if (first7 != 1 + 3 * (T + 1)) begin
      bad++;
      $display("FAIL single_latency got=%0d want=%0d", first7, 1 + 3 * (T + 1));
    end
    total++;
    if (n7 != D || n8 != 1) begin
      bad++;
      $display("FAIL single_door got=%0d/%0d want=%0d/1", n7, n8, D);
    end
    total++;
    if (door_q.size() != 1 || door_q[0] != 3 || status !== 4'd0) begin
      bad++;
      $display("FAIL single_stop got=%p st=%0d want='{3} st=0", door_q, status);
    end
  endtask

  // Phased request sequences; each phase runs until the car settles.
  task automatic run_phases(input string nm, input logic [7:0] u[3], input logic [7:0] d[3],
                            input logic [7:0] f[3], input int nph);
    for (int ph = 0; ph < nph; ph++) begin
      up_r |= u[ph]; dn_r |= d[ph]; fb_r |= f[ph];
      for (int c = 0; c < 400; c++) begin
        tick();
        total++;
        if (obs() !== exp_vec()) begin
          bad++;
          $display("FAIL %s ph=%0d c=%0d got=%h want=%h", nm, ph, c, obs(), exp_vec());
        end
        if (quiet()) break;
      end
      total++;
      if (!quiet()) begin
        bad++;
        $display("FAIL %s_timeout ph=%0d st=%0d want settle", nm, ph, m_status);
      end
    end
  endtask

  task automatic test_collective();
    logic [7:0] u[3] = '{8'h00, 8'h00, 8'h00};
    logic [7:0] d[3] = '{8'h20, 8'h00, 8'h00};
    logic [7:0] f[3] = '{8'h04, 8'h00, 8'h00};
    do_reset();
    run_phases("collective", u, d, f, 1);
    total++;
    if (door_q.size() != 2 || door_q[0] != 2 || door_q[1] != 5 || dir_up !== 1'b1) begin
      bad++;
      $display("FAIL collective_order got=%p dir=%0b want='{2,5} dir=1", door_q, dir_up);
    end
  endtask

  task automatic test_reverse();
    logic [7:0] u[3] = '{8'h00, 8'h00, 8'h00};
    logic [7:0] d[3] = '{8'h08, 8'h00, 8'h00};
    logic [7:0] f[3] = '{8'h40, 8'h00, 8'h00};
    do_reset();
    run_phases("reverse", u, d, f, 1);
    total++;
    if (door_q.size() != 2 || door_q[0] != 6 || door_q[1] != 3 || dir_up !== 1'b0) begin
      bad++;
      $display("FAIL reverse_order got=%p dir=%0b want='{6,3} dir=0", door_q, dir_up);
    end
  endtask

  task automatic test_dir_pref();
    logic [7:0] u[3] = '{8'h00, 8'h00, 8'h40};
    logic [7:0] d[3] = '{8'h00, 8'h00, 8'h00};
    logic [7:0] f[3] = '{8'h20, 8'h10, 8'h02};
    do_reset();
    run_phases("dirpref", u, d, f, 2);
    total++;
    if (floor !== 3'd4 || dir_up !== 1'b0) begin
      bad++;
      $display("FAIL dirpref_setup got=f%0d dir=%0b want=f4 dir=0", floor, dir_up);
    end
    door_q.delete();
    run_phases("dirpref", '{u[2], 8'h00, 8'h00}, '{8'h00, 8'h00, 8'h00}, '{f[2], 8'h00, 8'h00}, 1);
    total++;
    if (door_q.size() != 2 || door_q[0] != 1 || door_q[1] != 6) begin
      bad++;
      $display("FAIL dirpref_order got=%p want='{1,6}", door_q);
    end
  endtask

  task automatic test_reset_mid_move();
    do_reset();
    fb_r[5] = 1'b1;
    for (int c = 0; c < 2 + 2 * (T + 1) + 1; c++) begin
      tick();
      total++;
      if (obs() !== exp_vec()) begin
        bad++;
        $display("FAIL midreset c=%0d got=%h want=%h", c, obs(), exp_vec());
      end
    end
    total++;
    if (floor !== 3'd2 || status !== 4'd1) begin
      bad++;
      $display("FAIL midreset_pos got=f%0d st=%0d want=f2 st=1", floor, status);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (obs() !== {3'd0, 4'd0, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL midreset_clear got=%h want=%h", obs(), {3'd0, 4'd0, 1'b1, 1'b0});
    end
    door_q.delete();
    run_phases("midreset", '{8'h00, 8'h00, 8'h00}, '{8'h00, 8'h00, 8'h00}, '{8'h00, 8'h00, 8'h00}, 1);
    total++;
    if (door_q.size() != 1 || door_q[0] != 5) begin
      bad++;
      $display("FAIL midreset_reserve got=%p want='{5}", door_q);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 5) == 0) begin
        case ($urandom_range(0, 2))
          0:       up_r[$urandom_range(0, 7)] = 1'b1;
          1:       dn_r[$urandom_range(0, 7)] = 1'b1;
          default: fb_r[$urandom_range(0, 7)] = 1'b1;
        endcase
      end
      rst = ($urandom_range(0, 399) == 0);
      tick();
      rst = 1'b0;
      total++;
      if (obs() !== exp_vec()) begin
        bad++;
        $display("FAIL random c=%0d got=%h want=%h", c, obs(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_call();
    test_collective();
    test_reverse();
    test_dir_pref();
    test_reset_mid_move();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/elevator_dispatcher.md
Name: elevator_dispatcher

Overview:
Consumer end of the latched request vectors produced by the call/button input buffer. Reads the pending upcall/downcall/floor-button bits and runs a collective (SCAN) scheduling state machine. Drives the car floor index and the status code back to that buffer. Status 7 (DOOR_OPEN) is the acknowledge that clears the served floor's request bits.

Parameters:
TRAVEL_CYCLES, 4, clock cycles to travel one floor (>=1)
DOOR_CYCLES, 3, clock cycles status holds DOOR_OPEN (>=2)

Ports:
clk  input  1  system clock, all state updates on posedge
rst  input  1  synchronous active-high reset
upcall  input  8  latched hall up-call requests, bit i = floor i
downcall  input  8  latched hall down-call requests, bit i = floor i
floor_btn  input  8  latched in-car floor requests, bit i = floor i
floor  output  3  current car floor, 0..7
status  output  4  state code, values below
dir_up  output  1  current travel preference, 1 = up
door_open  output  1  high exactly while status == DOOR_OPEN

Behaviour:
- Clock is clk; reset is rst, synchronous, active-high. All outputs registered.
- Status codes: IDLE=0, MOVE_UP=1, MOVE_DOWN=2, DOOR_OPEN=7, DOOR_CLOSE=8. No other values are ever driven.
- Reset, including mid-move and mid-door: floor=0, status=IDLE, dir_up=1, door_open=0, travel and door counters=0. Takes effect on the next edge.
- Derived terms, combinational on the sampled inputs:
  - pend = upcall|downcall|floor_btn
  - above = |pend[7:floor+1]; below = |pend[floor-1:0]
  - above is 0 at floor 7; below is 0 at floor 0.
- IDLE:
  - pend[floor] set -> DOOR_OPEN.
  - Else if above and (dir_up or !below) -> MOVE_UP, dir_up=1.
  - Else if below -> MOVE_DOWN, dir_up=0.
  - Else remain IDLE, dir_up held.
- MOVE_UP / MOVE_DOWN:
  - Travel counter counts TRAVEL_CYCLES cycles. On the last one, floor increments/decrements by 1 and the counter clears.
  - Arrival evaluation uses the new floor in the following cycle (one evaluation cycle, status unchanged).
  - MOVE_UP stop at f: floor_btn[f] | upcall[f] | (downcall[f] & !above).
  - MOVE_DOWN stop at f: floor_btn[f] | downcall[f] | (upcall[f] & !below).
  - Stop -> DOOR_OPEN.
  - No stop and requests remain beyond in the travel direction -> continue moving.
  - Otherwise -> IDLE, which re-decides.
- Floor never passes 7 going up or 0 going down. A MOVE state at a boundary floor with nothing beyond goes to IDLE.
- DOOR_OPEN: held for exactly DOOR_CYCLES cycles, then DOOR_CLOSE. The buffer clears the floor's bits one cycle after first seeing status 7. New presses at that floor during DOOR_OPEN are absorbed (cleared).
- DOOR_CLOSE: exactly 1 cycle. It absorbs the buffer's one-cycle clear latency, then goes to IDLE.
- Requests whose bits change mid-travel are honoured at the next arrival evaluation. Requests deasserting mid-travel do not abort the current floor step.
- Simultaneous requests above and below while IDLE: current dir_up wins.

Decomposition:
- Shared package elevator_pkg:
  - status code constants: IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN, DOOR_CLOSE
  - NUM_FLOORS=8, FLOOR_W=3
- Natural sub-module: elevator_req_scan, purely combinational. Given pend, upcall, downcall, floor_btn, floor and dir_up, it produces above, below, stop_up and stop_down.
- Counters and FSM live in the top.

Test Plan:
- Reset 10 cycles, then no requests -> floor=0, status=0, dir_up=1, door_open=0 held for 50 cycles.
- floor_btn=8'h08 from floor 0, TRAVEL_CYCLES=4 -> status 1. floor reaches 3 after 12 travel cycles, then status 7 for 3 cycles, 8 for 1, then 0.
- At floor 0, floor_btn[2] and downcall[5] set -> stops at 2 (status 7). Continues up, stops at 5 because downcall with nothing above. dir_up stays 1 until the next demand below.
- Car moving up past floor 3, downcall[3] set, floor_btn[6] set -> no stop at 3. Stops at 6, then reverses: MOVE_DOWN, stops at 3.
- At floor 4 IDLE with dir_up=0, upcall[6] and floor_btn[1] set simultaneously -> MOVE_DOWN first to 1, then up to 6.
- rst asserted mid-MOVE_UP between floors 2 and 3 -> next edge floor=0, status=0, counter cleared. Pending inputs are re-served after rst deasserts.
